virtual_axi_full_memory: RTL and testbench

Behavioural-yet-synthesizable AXI4-full slave memory used as the external memory for the Paillier accelerator bench. It accepts INCR bursts from the accelerator's AXI master, serves operand reads from a preloaded word array, and stores result writes. It counts completed write bursts so the bench knows when TEST_TIMES operations are finished.

---
 rtl/virtual_axi_mem_pkg.sv | 30 +++
 rtl/virtual_axi_full_memory_if.sv | 63 ++++++
 rtl/virtual_axi_full_memory_word_array.sv | 52 +++++
 rtl/virtual_axi_full_memory.sv | 197 +++++++++++++++++++
 tb/tb_virtual_axi_full_memory.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/virtual_axi_mem_pkg.sv
// Shared constants, FSM state types and the preload pattern for the
// virtual AXI4-full slave memory.
package virtual_axi_mem_pkg;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;

    localparam logic [1:0] MODE_ENC      = 2'b00;
    localparam logic [1:0] MODE_DEC      = 2'b01;
    localparam logic [1:0] MODE_HOM_ADD  = 2'b10;
    localparam logic [1:0] MODE_SCAL_MUL = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // One 32-bit lane of the power-up pattern; a word is this lane replicated.
    function automatic logic [31:0] preload_lane(input logic [1:0]  mode,
                                                 input logic [15:0] idx);
        return {8'hA0, 6'b000000, mode, idx};
    endfunction

endpackage

// File: rtl/virtual_axi_full_memory_if.sv
// AXI4-full bus bundle between the accelerator master and the memory slave.
interface virtual_axi_full_memory_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 1
);
    logic [ID_WIDTH-1:0]     AWID;
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    logic [ID_WIDTH-1:0]     BID;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ID_WIDTH-1:0]     ARID;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [ID_WIDTH-1:0]     RID;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

endinterface

// File: rtl/virtual_axi_full_memory_word_array.sv
// Word array with a byte-enable write port and an asynchronous read port.
// Words never written return the power-up pattern, tracked by a written
// bitmap that is cleared at power-up only, so contents survive reset.
module axi_mem_word_array
    import virtual_axi_mem_pkg::*;
#(
    parameter int         DATA_WIDTH    = 128,
    parameter int         DEPTH         = 1024,
    parameter logic [1:0] PAILLIER_MODE = 2'b00,
    parameter int         IDX_W         = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        widx_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [IDX_W-1:0]        ridx_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    localparam int LANES  = DATA_WIDTH / 32;
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      written_q = '0;
    logic [DATA_WIDTH-1:0] wold_s;
    logic [DATA_WIDTH-1:0] wmerged_s;

    // Current contents seen by both ports (stored word or power-up pattern).
    always_comb begin
        rdata_o   = written_q[ridx_i] ? mem_q[ridx_i]
                                      : {LANES{preload_lane(PAILLIER_MODE, 16'(ridx_i))}};
        wold_s    = written_q[widx_i] ? mem_q[widx_i]
                                      : {LANES{preload_lane(PAILLIER_MODE, 16'(widx_i))}};
        wmerged_s = wold_s;
        for (int b = 0; b < NBYTES; b++) begin
            if (wstrb_i[b]) begin
                wmerged_s[8*b +: 8] = wdata_i[8*b +: 8];
            end else begin
                wmerged_s[8*b +: 8] = wold_s[8*b +: 8];
            end
        end
    end

    // Commit the merged word; no reset so contents persist across resets.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[widx_i]     <= wmerged_s;
            written_q[widx_i] <= 1'b1;
        end
    end

endmodule

// File: rtl/virtual_axi_full_memory.sv
// AXI4-full slave memory: independent write and read burst engines
// (one outstanding burst each) over a preloaded word array, plus a
// completed-write-burst counter and sticky done flag.
module virtual_axi_full_memory
    import virtual_axi_mem_pkg::*;
#(
    parameter logic [1:0] PAILLIER_MODE = 2'b00,
    parameter int         TEST_TIMES    = 1,
    parameter int         DATA_WIDTH    = 128,
    parameter int         ADDR_WIDTH    = 64,
    parameter int         ID_WIDTH      = 1,
    parameter int         DEPTH         = 1024
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESETN,
    virtual_axi_full_memory_if.slave     s_axi,
    output logic [31:0]                  wr_burst_cnt,
    output logic                         done
);
    localparam int ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = $clog2(DEPTH);

    wr_state_e             w_state_q, w_state_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [IDX_W-1:0]      w_idx_q, w_idx_d;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [31:0]           wr_cnt_q, wr_cnt_d;
    logic                  done_q, done_d, we_s;

    rd_state_e             r_state_q, r_state_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, mem_rdata_s;
    logic [IDX_W-1:0]      r_idx_q, r_idx_d, r_rd_idx_s;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic                  unused_s;

    // Size/burst type are ignored (every burst is full-width INCR).
    assign unused_s = ^{s_axi.AWSIZE, s_axi.AWBURST, s_axi.ARSIZE, s_axi.ARBURST,
                        s_axi.AWADDR, s_axi.ARADDR};

    axi_mem_word_array #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .PAILLIER_MODE(PAILLIER_MODE), .IDX_W(IDX_W)
    ) u_array (
        .clk_i(S_AXI_ACLK), .we_i(we_s), .widx_i(w_idx_q), .wdata_i(s_axi.WDATA),
        .wstrb_i(s_axi.WSTRB), .ridx_i(r_rd_idx_s), .rdata_o(mem_rdata_s)
    );

    // Write engine next state: address latch, data beats, response hold.
    always_comb begin
        w_state_d = w_state_q;  awready_d = awready_q;  wready_d = wready_q;
        bvalid_d  = bvalid_q;   bid_d     = bid_q;      w_idx_d  = w_idx_q;
        w_len_d   = w_len_q;    w_cnt_d   = w_cnt_q;    wr_cnt_d = wr_cnt_q;
        we_s      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi.AWVALID && awready_q) begin
                    bid_d     = s_axi.AWID;
                    w_idx_d   = s_axi.AWADDR[ADDR_LSB +: IDX_W];
                    w_len_d   = s_axi.AWLEN;
                    w_cnt_d   = 8'd0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end else begin
                    awready_d = 1'b1;
                end
            end
            W_DATA: begin
                if (s_axi.WVALID && wready_q) begin
                    we_s    = 1'b1;
                    w_idx_d = w_idx_q + IDX_W'(1);
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (s_axi.WLAST || (w_cnt_q == w_len_q)) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        w_state_d = W_RESP;
                    end else begin
                        wready_d  = 1'b1;
                    end
                end else begin
                    wready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (s_axi.BREADY && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wr_cnt_d  = wr_cnt_q + 32'd1;
                    w_state_d = W_IDLE;
                end else begin
                    bvalid_d  = 1'b1;
                end
            end
            default: begin
                awready_d = 1'b1;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
                w_state_d = W_IDLE;
            end
        endcase
        done_d = done_q | (wr_cnt_q >= 32'(TEST_TIMES));
    end

    // Read port address: incoming burst start while idle, else the next beat.
    always_comb begin
        if (r_state_q == R_IDLE) begin
            r_rd_idx_s = s_axi.ARADDR[ADDR_LSB +: IDX_W];
        end else begin
            r_rd_idx_s = r_idx_q + IDX_W'(1);
        end
    end

    // Read engine next state: beats issued back-to-back, held while stalled.
    always_comb begin
        r_state_d = r_state_q;  arready_d = arready_q;  rvalid_d = rvalid_q;
        rlast_d   = rlast_q;    rid_d     = rid_q;      rdata_d  = rdata_q;
        r_idx_d   = r_idx_q;    r_len_d   = r_len_q;    r_cnt_d  = r_cnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi.ARVALID && arready_q) begin
                    rid_d     = s_axi.ARID;
                    r_idx_d   = r_rd_idx_s;
                    r_len_d   = s_axi.ARLEN;
                    r_cnt_d   = 8'd0;
                    rdata_d   = mem_rdata_s;
                    rvalid_d  = 1'b1;
                    rlast_d   = (s_axi.ARLEN == 8'd0);
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axi.RREADY && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d = r_rd_idx_s;
                        r_cnt_d = r_cnt_q + 8'd1;
                        rdata_d = mem_rdata_s;
                        rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
                r_state_d = R_IDLE;
            end
        endcase
    end

    // State and output registers for both engines.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_q <= W_IDLE;  awready_q <= 1'b1;  wready_q <= 1'b0;
            bvalid_q  <= 1'b0;    bid_q     <= '0;    w_idx_q  <= '0;
            w_len_q   <= 8'd0;    w_cnt_q   <= 8'd0;  wr_cnt_q <= 32'd0;
            done_q    <= 1'b0;
            r_state_q <= R_IDLE;  arready_q <= 1'b1;  rvalid_q <= 1'b0;
            rlast_q   <= 1'b0;    rid_q     <= '0;    rdata_q  <= '0;
            r_idx_q   <= '0;      r_len_q   <= 8'd0;  r_cnt_q  <= 8'd0;
        end else begin
            w_state_q <= w_state_d;  awready_q <= awready_d;  wready_q <= wready_d;
            bvalid_q  <= bvalid_d;   bid_q     <= bid_d;      w_idx_q  <= w_idx_d;
            w_len_q   <= w_len_d;    w_cnt_q   <= w_cnt_d;    wr_cnt_q <= wr_cnt_d;
            done_q    <= done_d;
            r_state_q <= r_state_d;  arready_q <= arready_d;  rvalid_q <= rvalid_d;
            rlast_q   <= rlast_d;    rid_q     <= rid_d;      rdata_q  <= rdata_d;
            r_idx_q   <= r_idx_d;    r_len_q   <= r_len_d;    r_cnt_q  <= r_cnt_d;
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BID     = bid_q;
    assign s_axi.BRESP   = RESP_OKAY;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RLAST   = rlast_q;
    assign s_axi.RID     = rid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = RESP_OKAY;
    assign wr_burst_cnt  = wr_cnt_q;
    assign done          = done_q;

endmodule

// File: tb/tb_virtual_axi_full_memory.sv
// Directed plus randomized bench for the virtual AXI4-full memory, checked
// against a plain array model of the memory contents.
module tb_virtual_axi_full_memory;
    localparam int         DW    = 128;
    localparam int         AW    = 64;
    localparam int         IDW   = 1;
    localparam int         DEPTH = 1024;
    localparam int         NB    = DW / 8;
    localparam logic [1:0] MODE  = 2'b01;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    virtual_axi_full_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IDW)) bus ();
    logic [31:0] wr_burst_cnt;
    logic        done;

    virtual_axi_full_memory #(
        .PAILLIER_MODE(MODE), .TEST_TIMES(1), .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW), .ID_WIDTH(IDW), .DEPTH(DEPTH)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(bus),
        .wr_burst_cnt(wr_burst_cnt), .done(done)
    );

    int total = 0;
    int bad = 0;
    int exp_bursts = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] wdat [256];
    logic [NB-1:0] wstb [256];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input int wlast_beat, input int bdelay);
        int idx, nb, n;
        idx = int'(addr[13:4]);
        nb  = (wlast_beat >= 0 && wlast_beat < int'(len)) ? wlast_beat + 1 : int'(len) + 1;
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
        bus.AWSIZE = 3'd4; bus.AWBURST = 2'b01; bus.AWVALID = 1'b1;
        n = 0;
        while (bus.AWREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("awready", DW'(bus.AWREADY), DW'(1));
        @(negedge clk);
        bus.AWVALID = 1'b0;
        for (int b = 0; b < nb; b++) begin
            bus.WDATA = wdat[b]; bus.WSTRB = wstb[b];
            bus.WLAST = (b == wlast_beat); bus.WVALID = 1'b1;
            n = 0;
            while (bus.WREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            check("wready", DW'(bus.WREADY), DW'(1));
            @(negedge clk);
            for (int k = 0; k < NB; k++)
                if (wstb[b][k]) model[(idx + b) % DEPTH][8*k +: 8] = wdat[b][8*k +: 8];
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        check("wready_off", DW'(bus.WREADY), DW'(0));
        check("bvalid", DW'(bus.BVALID), DW'(1));
        for (int d = 0; d < bdelay; d++) begin
            @(negedge clk);
            check("bvalid_hold", DW'(bus.BVALID), DW'(1));
        end
        check("bid", DW'(bus.BID), DW'(id));
        check("bresp", DW'(bus.BRESP), DW'(0));
        bus.BREADY = 1'b1;
        @(negedge clk);
        bus.BREADY = 1'b0;
        exp_bursts++;
        check("bvalid_off", DW'(bus.BVALID), DW'(0));
        check("awready_back", DW'(bus.AWREADY), DW'(1));
        check("wr_burst_cnt", DW'(wr_burst_cnt), DW'(exp_bursts));
    endtask

    task automatic axi_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input bit stall);
        int idx, n;
        logic [DW-1:0] exp;
        idx = int'(addr[13:4]);
        bus.RREADY = !stall;
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len;
        bus.ARSIZE = 3'd4; bus.ARBURST = 2'b01; bus.ARVALID = 1'b1;
        n = 0;
        while (bus.ARREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("arready", DW'(bus.ARREADY), DW'(1));
        @(negedge clk);
        bus.ARVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            exp = model[(idx + b) % DEPTH];
            check("rvalid", DW'(bus.RVALID), DW'(1));
            check("rdata", bus.RDATA, exp);
            check("rlast", DW'(bus.RLAST), DW'(b == int'(len)));
            check("rid", DW'(bus.RID), DW'(id));
            if (stall) begin
                @(negedge clk);
                check("rvalid_stall", DW'(bus.RVALID), DW'(1));
                check("rdata_stall", bus.RDATA, exp);
                check("rlast_stall", DW'(bus.RLAST), DW'(b == int'(len)));
                bus.RREADY = 1'b1;
                @(negedge clk);
                bus.RREADY = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        bus.RREADY = 1'b0;
        check("rvalid_off", DW'(bus.RVALID), DW'(0));
        check("arready_back", DW'(bus.ARREADY), DW'(1));
    endtask

    initial begin
        logic [15:0] i16;
        logic [AW-1:0] a;
        logic [7:0] l;
        for (int i = 0; i < DEPTH; i++) begin
            i16 = 16'(i);
            model[i] = {4{{8'hA0, 6'b000000, MODE, i16}}};
        end
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.BREADY = 1'b0;
        bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = 8'd0; bus.AWSIZE = 3'd4; bus.AWBURST = 2'b01;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = 8'd0; bus.ARSIZE = 3'd4; bus.ARBURST = 2'b01;
        bus.WDATA = '0; bus.WSTRB = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset / idle state
        check("rst_awready", DW'(bus.AWREADY), DW'(1));
        check("rst_arready", DW'(bus.ARREADY), DW'(1));
        check("rst_wready", DW'(bus.WREADY), DW'(0));
        check("rst_bvalid", DW'(bus.BVALID), DW'(0));
        check("rst_rvalid", DW'(bus.RVALID), DW'(0));
        check("rst_rdata", bus.RDATA, '0);
        check("rst_cnt", DW'(wr_burst_cnt), DW'(0));
        check("rst_done", DW'(done), DW'(0));

        // Preload read: words 2 and 3
        check("preload_w2", model[2], {4{32'hA001_0002}});
        axi_read(1'b1, 64'h20, 8'd1, 1'b0);
        check("done_before_write", DW'(done), DW'(0));

        // Full-strobe 4-beat write then readback
        for (int b = 0; b < 4; b++) begin wdat[b] = DW'(b); wstb[b] = '1; end
        axi_write(1'b1, 64'h0, 8'd3, 3, 0);
        @(negedge clk);
        check("done", DW'(done), DW'(1));
        axi_read(1'b0, 64'h0, 8'd3, 1'b0);

        // Partial strobe on word 5
        wdat[0] = '1; wstb[0] = 16'h000F;
        axi_write(1'b0, 64'h50, 8'd0, 0, 0);
        axi_read(1'b0, 64'h50, 8'd0, 1'b0);

        // Backpressure on both response and read data
        for (int b = 0; b < 4; b++) begin
            wdat[b] = {$urandom, $urandom, $urandom, $urandom}; wstb[b] = '1;
        end
        axi_write(1'b1, 64'h400, 8'd3, 3, 5);
        axi_read(1'b1, 64'h400, 8'd3, 1'b1);

        // Early WLAST, and a burst sent without WLAST that must stop at AWLEN
        for (int b = 0; b < 4; b++) begin
            wdat[b] = {$urandom, $urandom, $urandom, $urandom}; wstb[b] = '1;
        end
        axi_write(1'b0, 64'h100, 8'd3, 1, 0);
        axi_read(1'b0, 64'h100, 8'd3, 1'b0);
        axi_write(1'b1, 64'h200, 8'd0, -1, 1);
        axi_read(1'b1, 64'h200, 8'd1, 1'b0);

        // Randomized bursts
        for (int it = 0; it < 8; it++) begin
            a = {50'd0, 10'($urandom_range(0, DEPTH - 1)), 4'd0};
            l = 8'($urandom_range(0, 7));
            for (int b = 0; b < 8; b++) begin
                wdat[b] = {$urandom, $urandom, $urandom, $urandom};
                wstb[b] = 16'($urandom);
            end
            axi_write(1'($urandom), a, l, int'(l), $urandom_range(0, 3));
            axi_read(1'($urandom), a, 8'($urandom_range(0, 7)), 1'($urandom));
        end

        // Wrap-around at the top of the array
        axi_read(1'b0, 64'(DEPTH * 16 - 16), 8'd1, 1'b0);
        wdat[0] = {$urandom, $urandom, $urandom, $urandom}; wstb[0] = '1;
        wdat[1] = {$urandom, $urandom, $urandom, $urandom}; wstb[1] = '1;
        axi_write(1'b1, 64'(DEPTH * 16 - 16), 8'd1, 1, 0);
        axi_read(1'b1, 64'(DEPTH * 16 - 16), 8'd1, 1'b1);

        // Reset in the middle of a read burst
        bus.RREADY = 1'b1;
        bus.ARID = 1'b0; bus.ARADDR = 64'h0; bus.ARLEN = 8'd7; bus.ARVALID = 1'b1;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", DW'(bus.RVALID), DW'(0));
        check("midrst_arready", DW'(bus.ARREADY), DW'(1));
        @(negedge clk);
        bus.RREADY = 1'b0;
        rst_n = 1'b1;
        exp_bursts = 0;
        @(negedge clk);
        check("postrst_rvalid", DW'(bus.RVALID), DW'(0));
        check("postrst_arready", DW'(bus.ARREADY), DW'(1));
        check("postrst_awready", DW'(bus.AWREADY), DW'(1));
        check("postrst_cnt", DW'(wr_burst_cnt), DW'(0));
        check("postrst_done", DW'(done), DW'(0));
        axi_read(1'b0, 64'h0, 8'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
